// File: rtl/inta_sequencer.sv
// Processor-side 8259 interrupt-acknowledge sequencer: drives the INTA_N pulse train,
// captures the PIC data bytes and presents the vector. Optional macro CALL_CHECK_EN.
module inta_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT,
  input  logic        enable,
  input  logic        mode_8086,
  input  logic [7:0]  D,
  output logic        INTA_N,
  output logic        busy,
  output logic        vector_valid,
  output logic [15:0] vector,
  input  logic        vector_ack,
  output logic        opcode_err
);

  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, VALID} state_t;

  state_t           state;
  logic [1:0]       pulse_num;
  logic [CNT_W-1:0] width_cnt;
  logic             mode_lat;
  logic [7:0]       lo_byte;
  logic             last_pulse;

  // 8086 acknowledges with two pulses, 8080 with three
  assign last_pulse = mode_lat ? (pulse_num == 2'd1) : (pulse_num == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pulse_num    <= 2'd0;
      width_cnt    <= '0;
      mode_lat     <= 1'b0;
      lo_byte      <= 8'h00;
      INTA_N       <= 1'b1;
      busy         <= 1'b0;
      vector_valid <= 1'b0;
      vector       <= 16'h0000;
`ifdef CALL_CHECK_EN
      opcode_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (INT && enable) begin
            state     <= PULSE;
            pulse_num <= 2'd0;
            width_cnt <= '0;
            mode_lat  <= mode_8086;
            INTA_N    <= 1'b0;
            busy      <= 1'b1;
`ifdef CALL_CHECK_EN
            opcode_err <= 1'b0;
`endif
          end
        end
        PULSE: begin
          if (width_cnt == PULSE_LAST) begin
            width_cnt <= '0;
            INTA_N    <= 1'b1;
            // D is sampled on the last edge INTA_N is still low
            case (pulse_num)
              2'd0: begin
`ifdef CALL_CHECK_EN
                if (!mode_lat && (D != 8'hCD))
                  opcode_err <= 1'b1;
`endif
              end
              2'd1: begin
                lo_byte <= D;
                if (mode_lat)
                  vector <= {8'h00, D};
              end
              default: vector <= {D, lo_byte};
            endcase
            if (last_pulse) begin
              state        <= VALID;
              busy         <= 1'b0;
              vector_valid <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            width_cnt <= width_cnt + 1'b1;
          end
        end
        GAP: begin
          if (width_cnt == GAP_LAST) begin
            state     <= PULSE;
            width_cnt <= '0;
            pulse_num <= pulse_num + 2'd1;
            INTA_N    <= 1'b0;
          end else begin
            width_cnt <= width_cnt + 1'b1;
          end
        end
        VALID: begin
          if (vector_ack) begin
            vector_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CALL_CHECK_EN
  assign opcode_err = 1'b0;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer with PULSE_W=2, GAP_W=1 (pulse period of 3 edges).
module tb_inta_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        INT;
  logic        enable;
  logic        mode_8086;
  logic [7:0]  D;
  logic        INTA_N;
  logic        busy;
  logic        vector_valid;
  logic [15:0] vector;
  logic        vector_ack;
  logic        opcode_err;

  int n_vec = 0;
  int n_err = 0;

  inta_sequencer #(.PULSE_W(2), .GAP_W(1)) dut (
    .clk(clk), .reset(reset), .INT(INT), .enable(enable), .mode_8086(mode_8086),
    .D(D), .INTA_N(INTA_N), .busy(busy), .vector_valid(vector_valid),
    .vector(vector), .vector_ack(vector_ack), .opcode_err(opcode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete acknowledge; edge e captures on e%3==2, byte index e/3.
  task automatic run_seq(input bit m8086, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [15:0] exp_vec,
                         input bit exp_err, input bit ack_noise, input bit chain);
    logic [7:0] bytes [3];
    int n;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    n = m8086 ? 6 : 9;
    INT = 1'b1; enable = 1'b1; mode_8086 = m8086;
    for (int e = 0; e < n; e++) begin
      D = bytes[e / 3];
      vector_ack = ack_noise && (e < n - 1);
      step();
      if (e == 0) begin
        INT = 1'b0; enable = 1'b0; mode_8086 = ~m8086;
      end
      chk($sformatf("inta_e%0d", e), {15'd0, INTA_N}, {15'd0, (e % 3) == 2});
      chk($sformatf("valid_e%0d", e), {15'd0, vector_valid}, {15'd0, e == n - 1});
      chk($sformatf("busy_e%0d", e), {15'd0, busy}, {15'd0, e != n - 1});
      chk($sformatf("operr_e%0d", e), {15'd0, opcode_err}, {15'd0, exp_err && (e >= 2)});
    end
    chk("vector", vector, exp_vec);
    vector_ack = 1'b0;
    D = 8'hFF;
    for (int h = 0; h < 5; h++) begin
      step();
      chk("hold_valid", {15'd0, vector_valid}, 16'd1);
      chk("hold_vector", vector, exp_vec);
      chk("hold_inta", {15'd0, INTA_N}, 16'd1);
    end
    vector_ack = 1'b1;
    if (chain) begin
      INT = 1'b1; enable = 1'b1;
    end
    step();
    vector_ack = 1'b0;
    chk("ack_valid", {15'd0, vector_valid}, 16'd0);
    chk("ack_inta", {15'd0, INTA_N}, 16'd1);
    chk("ack_operr", {15'd0, opcode_err}, {15'd0, exp_err});
  endtask

  initial begin
    bit call_chk;
`ifdef CALL_CHECK_EN
    call_chk = 1'b1;
`else
    call_chk = 1'b0;
`endif
    reset = 1'b1; INT = 1'b0; enable = 1'b0; mode_8086 = 1'b1; D = 8'h00; vector_ack = 1'b0;
    step(); step();
    chk("rst_inta", {15'd0, INTA_N}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_valid", {15'd0, vector_valid}, 16'd0);
    chk("rst_vector", vector, 16'h0000);
    chk("rst_operr", {15'd0, opcode_err}, 16'd0);
    #4 reset = 1'b0;

    // enable low blocks starts while INT is high
    INT = 1'b1; enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("en_off_inta", {15'd0, INTA_N}, 16'd1);
    end

    run_seq(1'b1, 8'h11, 8'h4A, 8'h00, 16'h004A, 1'b0, 1'b0, 1'b1);
    run_seq(1'b0, 8'hCD, 8'h20, 8'h13, 16'h1320, 1'b0, 1'b1, 1'b0);
    run_seq(1'b0, 8'h00, 8'h34, 8'h12, 16'h1234, call_chk, 1'b0, 1'b0);
    run_seq(1'b1, 8'hCD, 8'hFF, 8'h55, 16'h00FF, 1'b0, 1'b0, 1'b0);

    // async reset during the second low pulse
    INT = 1'b1; enable = 1'b1; mode_8086 = 1'b1; D = 8'h77;
    step();
    INT = 1'b0;
    step(); step(); step();
    chk("pre_rst_inta", {15'd0, INTA_N}, 16'd0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_inta", {15'd0, INTA_N}, 16'd1);
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_valid", {15'd0, vector_valid}, 16'd0);
      chk("post_rst_inta", {15'd0, INTA_N}, 16'd1);
    end
    chk("post_rst_vector", vector, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
